// File: rtl/pipe_ctrl.sv
// rtl/pipe_ctrl.sv - RAW-hazard scoreboard and stall/flush/hold sequencing for the core pipeline
module pipe_ctrl #(
  parameter int DEPTH     = 3,
  parameter int WB_BYPASS = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  rs1_addr_i,
  input  logic        rs1_ren_i,
  input  logic [4:0]  rs2_addr_i,
  input  logic        rs2_ren_i,
  input  logic [4:0]  rd_addr_i,
  input  logic        reg_wen_i,
  input  logic        jump_en_i,
  input  logic [31:0] jump_addr_i,
  input  logic        ext_hold_i,
  output logic        hold_pc_o,
  output logic        hold_if_id_o,
  output logic        bubble_id_ex_o,
  output logic        flush_o,
  output logic        jump_o,
  output logic [31:0] jump_addr_o,
  output logic [31:0] stall_cnt_o
);

  typedef enum logic [1:0] {
    MODE_RUN,
    MODE_STALL,
    MODE_FLUSH,
    MODE_HOLD
  } mode_t;

  // Entry 0 is the instruction in EX; entry DEPTH-1 is writing the register file.
  logic [DEPTH-1:0] r_valid;
  logic [4:0]       r_rd [DEPTH];
  logic [31:0]      r_stall_cnt;

  logic             w_hazard;
  mode_t            w_mode;

  // Compare both source operands against every scoreboard entry that can still hazard;
  // with bypass the entry being written back this cycle is already visible in the regfile.
  always_comb begin
    w_hazard = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      if (r_valid[k] && (r_rd[k] != 5'd0) && !((WB_BYPASS == 1) && (k == DEPTH - 1))) begin
        if (rs1_ren_i && (r_rd[k] == rs1_addr_i)) w_hazard = 1'b1;
        if (rs2_ren_i && (r_rd[k] == rs2_addr_i)) w_hazard = 1'b1;
      end
    end
  end

  // Priority select: external hold beats jump flush beats hazard stall beats run.
  always_comb begin
    w_mode = MODE_RUN;
    if (ext_hold_i)     w_mode = MODE_HOLD;
    else if (jump_en_i) w_mode = MODE_FLUSH;
    else if (w_hazard)  w_mode = MODE_STALL;
  end

  // Drive stage controls from the selected mode; all forced quiet while in reset.
  always_comb begin
    hold_pc_o      = 1'b0;
    hold_if_id_o   = 1'b0;
    bubble_id_ex_o = 1'b0;
    flush_o        = 1'b0;
    jump_o         = 1'b0;
    if (!rst) begin
      unique case (w_mode)
        MODE_HOLD: begin
          hold_pc_o    = 1'b1;
          hold_if_id_o = 1'b1;
        end
        MODE_FLUSH: begin
          flush_o = 1'b1;
          jump_o  = 1'b1;
        end
        MODE_STALL: begin
          hold_pc_o      = 1'b1;
          hold_if_id_o   = 1'b1;
          bubble_id_ex_o = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Advance the scoreboard unless frozen; only a RUN cycle inserts a real producer,
  // stalls and flushes push a bubble into EX.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid     <= '0;
      r_stall_cnt <= '0;
      for (int k = 0; k < DEPTH; k++) r_rd[k] <= 5'd0;
    end else if (w_mode != MODE_HOLD) begin
      for (int k = DEPTH - 1; k > 0; k--) begin
        r_valid[k] <= r_valid[k-1];
        r_rd[k]    <= r_rd[k-1];
      end
      r_valid[0] <= (w_mode == MODE_RUN) && reg_wen_i;
      r_rd[0]    <= (w_mode == MODE_RUN) ? rd_addr_i : 5'd0;
      if (w_mode == MODE_STALL) r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end

  assign jump_addr_o = jump_addr_i;
  assign stall_cnt_o = r_stall_cnt;

endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Pipeline sequencing controller for the phase-1 RISC-V core. It tracks in-flight register writes between the decode stage and the register file in a scoreboard. It stalls the PC and IF/ID and injects a bubble into ID/EX on read-after-write hazards, flushes IF/ID and ID/EX on taken jumps, and freezes the whole pipe on external hold requests. It sits beside `id`, taking the decoded register addresses and write enable, and drives the hold and flush inputs of `pc_reg`, `if_id` and `id_ex`.

## Interface
- `DEPTH`, 3: number of stages between ID and register-file write (EX, MEM, WB); minimum 1.
- `WB_BYPASS`, 1: 1 means the register file returns same-cycle write data, so the oldest scoreboard entry never causes a hazard.
- `clk  input  1  core clock`
- `rst  input  1  reset; synchronous, active-high`
- `rs1_addr_i  input  5  rs1 address from id`
- `rs1_ren_i  input  1  id instruction reads rs1`
- `rs2_addr_i  input  5  rs2 address from id`
- `rs2_ren_i  input  1  id instruction reads rs2`
- `rd_addr_i  input  5  rd address from id`
- `reg_wen_i  input  1  id instruction writes rd`
- `jump_en_i  input  1  taken jump/branch resolved in EX`
- `jump_addr_i  input  32  jump target from EX`
- `ext_hold_i  input  1  external freeze request (memory wait)`
- `hold_pc_o  output  1  pc_reg keeps current PC`
- `hold_if_id_o  output  1  if_id keeps contents`
- `bubble_id_ex_o  output  1  id_ex loads NOP (rd_addr=0, reg_wen=0)`
- `flush_o  output  1  if_id and id_ex load NOP`
- `jump_o  output  1  pc_reg loads jump_addr_o`
- `jump_addr_o  output  32  target passed to pc_reg`
- `stall_cnt_o  output  32  count of RAW-hazard stall cycles`

## Operation
- Scoreboard: DEPTH entries `{valid, rd[4:0]}`. Entry 0 is the instruction in EX; entry DEPTH-1 is the instruction writing the register file this cycle.
- Entry k matches source s when: valid, rd ≠ 0, rd == rs_s_addr_i, rs_s_ren_i = 1, and not (WB_BYPASS = 1 and k = DEPTH-1).
- `hazard` = any entry matches rs1 or rs2. Reads of x0 never hazard.
- Priority, evaluated each cycle: ext_hold_i > jump_en_i > hazard > run.
  - HOLD (ext_hold_i = 1): hold_pc_o = hold_if_id_o = 1; bubble_id_ex_o = flush_o = jump_o = 0. Scoreboard frozen. stall_cnt_o unchanged. A concurrent jump_en_i is ignored; EX is frozen and re-presents the jump after the hold ends.
  - FLUSH (jump_en_i = 1): flush_o = jump_o = 1; hold outputs and bubble = 0. Scoreboard shifts and entry 0 loads invalid. The hazard is discarded and not counted.
  - STALL (hazard): hold_pc_o = hold_if_id_o = bubble_id_ex_o = 1. Scoreboard shifts and entry 0 loads invalid. stall_cnt_o increments by 1.
  - RUN: all control outputs 0. Scoreboard shifts; entry 0 loads `{reg_wen_i, rd_addr_i}`.
- Shift: entry k+1 ← entry k; the old entry DEPTH-1 is dropped.
- jump_addr_o = jump_addr_i at all times; only jump_o is gated.
- stall_cnt_o wraps from 0xFFFFFFFF to 0.

## Timing
- Control outputs are combinational from the registered scoreboard and the current inputs, giving zero-cycle stall and flush response. The scoreboard and stall_cnt_o update on posedge clk.
- Reset (rst = 1 at posedge): all entries invalid, stall_cnt_o = 0. While rst = 1, hold_pc_o, hold_if_id_o, bubble_id_ex_o, flush_o and jump_o are forced to 0. Reset asserted mid-stall or mid-hold clears everything by the next cycle.
- Producer issued at cycle t, consumer in ID at t+1: stall length is DEPTH-1-WB_BYPASS+1 cycles minus the consumer's distance. With the defaults, an adjacent dependent pair stalls 2 cycles and a gap of one independent instruction stalls 1 cycle.
- Jump flush lasts exactly one cycle per jump_en_i cycle.
- A hazard against multiple entries stalls until the youngest matching entry clears.

## Test plan
- Reset: hold rst = 1 for 2 cycles with random inputs -> all control outputs 0, stall_cnt_o = 0. First RUN cycle then loads entry 0.
- RAW hazard: issue rd = 1 with wen = 1, then ID reads rs1 = 1 -> hold_pc_o, hold_if_id_o and bubble_id_ex_o = 1 for exactly 2 cycles, then 0; stall_cnt_o = 2.
- x0 and disabled reads: write rd = 0 then read rs1 = 0 -> no stall. Write rd = 5 then present rs2 = 5 with rs2_ren_i = 0 -> no stall.
- Jump during hazard: hazard active and jump_en_i = 1, jump_addr_i = 0x0000_0040 -> flush_o = jump_o = 1, jump_addr_o = 0x40, holds 0, stall_cnt_o unchanged; entry 0 invalid next cycle.
- External hold mid-stall: after 1 stall cycle, ext_hold_i = 1 for 3 cycles -> holds = 1, bubble = 0, scoreboard frozen, stall_cnt_o stays 1. After release, 1 further stall cycle, final stall_cnt_o = 2.
- DEPTH = 1, WB_BYPASS = 0 build: adjacent dependent pair -> exactly 1 stall cycle.
